// File: rtl/scc_pkg.sv
// Shared encodings for the SCC memory front-end: FSM states, access owner,
// and the bit positions inside the sticky error vector.
package scc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_TMO   = 1;
  localparam int ERR_W     = 2;

  // Number of low byte-address bits that must be zero for a word access.
  function automatic int align_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/scc_arb_prio.sv
// Grant selection between fetch and data requests. Data normally wins; a
// pending fetch is forced through after STARVE_MAX back-to-back data grants.
module scc_arb_prio
  import scc_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic grant_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_if,
  output logic grant_d
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_reg;
  logic [CW-1:0] starve_next;
  logic          starved;

  always_comb begin
    starved  = if_req && (starve_reg == CW'(STARVE_MAX));
    grant_d  = grant_en && d_req && !starved;
    grant_if = grant_en && if_req && !grant_d;
  end

  // The count only tracks data grants that overtook a waiting fetch.
  always_comb begin
    starve_next = starve_reg;
    if (!if_req || grant_if) begin
      starve_next = '0;
    end else if (grant_d) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_reg <= '0;
    end else if (clk_en) begin
      starve_reg <= starve_next;
    end
  end

endmodule

// File: rtl/scc_mem_arbiter.sv
// Single-port memory front-end shared by instruction fetch and data access:
// req/ack handshake, alignment check, ack timeout and halt drain.
module scc_mem_arbiter
  import scc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ERR_W-1:0]  err_bits,
  output logic              halted
);

  localparam int ALIGN_B = align_bits(DATA_W);
  localparam int TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t             state_reg,    state_next;
  owner_t             owner_reg,    owner_next;
  logic               we_reg,       we_next;
  logic [ADDR_W-1:0]  addr_reg,     addr_next;
  logic [DATA_W-1:0]  wdata_reg,    wdata_next;
  logic [TW-1:0]      tmo_reg,      tmo_next;
  logic [ERR_W-1:0]   err_reg,      err_next;
  logic               if_valid_reg, if_valid_next;
  logic               d_valid_reg,  d_valid_next;
  logic [DATA_W-1:0]  if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]  d_rdata_reg,  d_rdata_next;

  logic               grant_en;
  logic               grant_if;
  logic               grant_d;
  logic [ADDR_W-1:0]  gnt_addr;
  logic               gnt_misaligned;
  logic               pulse;
  owner_t             pulse_owner;
  logic [DATA_W-1:0]  pulse_data;

  // No grant while a valid pulse is out: the requester still holds its
  // request this cycle and would otherwise be served twice.
  assign grant_en = (state_reg == ST_IDLE) && !halt && !if_valid_reg && !d_valid_reg;
  assign gnt_addr = grant_d ? d_addr : if_addr;

  generate
    if (ALIGN_B > 0) begin : g_align
      assign gnt_misaligned = |gnt_addr[ALIGN_B-1:0];
    end else begin : g_no_align
      assign gnt_misaligned = 1'b0;
    end
  endgenerate

  scc_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .grant_en (grant_en),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    tmo_next      = tmo_reg;
    err_next      = err_reg;
    if_valid_next = 1'b0;
    d_valid_next  = 1'b0;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    pulse         = 1'b0;
    pulse_owner   = owner_reg;
    pulse_data    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (halt) begin
          state_next = ST_HALTED;
        end else if (grant_if || grant_d) begin
          if (gnt_misaligned) begin
            err_next[ERR_ALIGN] = 1'b1;
            pulse               = 1'b1;
            pulse_owner         = grant_d ? OWN_D : OWN_IF;
          end else begin
            state_next = ST_WAIT;
            owner_next = grant_d ? OWN_D : OWN_IF;
            we_next    = grant_d && d_we;
            addr_next  = gnt_addr;
            wdata_next = grant_d ? d_wdata : '0;
            tmo_next   = '0;
          end
        end
      end

      ST_WAIT: begin
        // An ack on the final timeout cycle still completes normally.
        if (mem_ack) begin
          state_next = ST_IDLE;
          pulse      = 1'b1;
          pulse_data = we_reg ? '0 : mem_rdata;
        end else if (tmo_reg == TMO_LAST) begin
          state_next        = ST_IDLE;
          err_next[ERR_TMO] = 1'b1;
          pulse             = 1'b1;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_HALTED;
      end
    endcase

    if (pulse) begin
      if (pulse_owner == OWN_D) begin
        d_valid_next = 1'b1;
        d_rdata_next = pulse_data;
      end else begin
        if_valid_next = 1'b1;
        if_rdata_next = pulse_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= OWN_IF;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      tmo_reg      <= '0;
      err_reg      <= '0;
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else if (clk_en) begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      tmo_reg      <= tmo_next;
      err_reg      <= err_next;
      if_valid_reg <= if_valid_next;
      d_valid_reg  <= d_valid_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  // mem_req follows the state register so reset removes it immediately.
  assign mem_req   = (state_reg == ST_WAIT);
  assign mem_we    = we_reg && mem_req;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign if_valid  = if_valid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_valid   = d_valid_reg;
  assign d_rdata   = d_rdata_reg;
  assign err_bits  = err_reg;
  assign halted    = (state_reg == ST_HALTED);

endmodule
